// File: rtl/lcd_pkg.sv
// Shared constants, state/instruction enums and address helpers for the HD44780 bus responder.
package lcd_pkg;

    localparam logic [7:0]  SPACE_CHAR = 8'h20;
    localparam logic [6:0]  LINE0_BASE = 7'h00;
    localparam logic [6:0]  LINE1_BASE = 7'h40;
    localparam int unsigned LINE_LEN   = 40;
    localparam int unsigned DDRAM_SIZE = 2 * LINE_LEN;

    localparam logic [7:0] OP_CLEAR   = 8'h01;
    localparam logic [7:0] OP_HOME    = 8'h02;
    localparam logic [7:0] OP_ENTRY   = 8'h04;
    localparam logic [7:0] OP_DISPLAY = 8'h08;
    localparam logic [7:0] OP_SHIFT   = 8'h10;
    localparam logic [7:0] OP_FUNC    = 8'h20;
    localparam logic [7:0] OP_CGRAM   = 8'h40;
    localparam logic [7:0] OP_DDRAM   = 8'h80;

    typedef enum logic [1:0] {CLEAR, IDLE, EXEC} state_t;

    typedef enum logic [3:0] {
        I_NOP, I_CLEAR, I_HOME, I_ENTRY, I_DISPLAY, I_SHIFT, I_FUNC, I_CGRAM, I_DDRAM
    } instr_t;

    // Instruction class is selected by the highest set bit of the byte.
    function automatic instr_t instr_decode(input logic [7:0] d);
        if ((d & OP_DDRAM)   != '0) return I_DDRAM;
        if ((d & OP_CGRAM)   != '0) return I_CGRAM;
        if ((d & OP_FUNC)    != '0) return I_FUNC;
        if ((d & OP_SHIFT)   != '0) return I_SHIFT;
        if ((d & OP_DISPLAY) != '0) return I_DISPLAY;
        if ((d & OP_ENTRY)   != '0) return I_ENTRY;
        if ((d & OP_HOME)    != '0) return I_HOME;
        if ((d & OP_CLEAR)   != '0) return I_CLEAR;
        return I_NOP;
    endfunction

    // Address counter step; the two lines form one 80-position ring.
    function automatic logic [6:0] ac_step(input logic [6:0] ac, input logic inc);
        if (inc) begin
            if (ac == LINE0_BASE + 7'(LINE_LEN - 1)) return LINE1_BASE;
            if (ac == LINE1_BASE + 7'(LINE_LEN - 1)) return LINE0_BASE;
            return ac + 7'd1;
        end
        if (ac == LINE0_BASE) return LINE1_BASE + 7'(LINE_LEN - 1);
        if (ac == LINE1_BASE) return LINE0_BASE + 7'(LINE_LEN - 1);
        return ac - 7'd1;
    endfunction

    function automatic logic [6:0] ac_set(input logic [6:0] d);
        return (d[5:0] >= 6'(LINE_LEN)) ? {d[6], 6'd0} : d;
    endfunction

    function automatic logic [5:0] ofs_step(input logic [5:0] s, input logic inc);
        if (inc) return (s == 6'(LINE_LEN - 1)) ? 6'd0 : s + 6'd1;
        return (s == 6'd0) ? 6'(LINE_LEN - 1) : s - 6'd1;
    endfunction

    function automatic logic col_valid(input logic [6:0] a);
        return a[5:0] < 6'(LINE_LEN);
    endfunction

    function automatic logic [6:0] ddram_index(input logic [6:0] a);
        return a[6] ? 7'(LINE_LEN) + {1'b0, a[5:0]} : {1'b0, a[5:0]};
    endfunction

endpackage

// File: rtl/lcd_bus_sync.sv
// Two-flop synchronizer for the HD44780 bus with falling-edge detection on EN.
module lcd_bus_sync (
    input  logic       clk,
    input  logic       rst,
    input  logic       lcd_en,
    input  logic       lcd_rs,
    input  logic       lcd_rw,
    input  logic [7:0] lcd_data,
    output logic       txn_valid,
    output logic       txn_rs,
    output logic       txn_rw,
    output logic [7:0] txn_byte
);

    logic [10:0] meta;
    logic [10:0] sync;
    logic        en_prev;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta    <= '0;
            sync    <= '0;
            en_prev <= 1'b0;
        end else begin
            meta    <= {lcd_en, lcd_rs, lcd_rw, lcd_data};
            sync    <= meta;
            en_prev <= sync[10];
        end
    end

    // RS/RW/data travel with EN, so the synchronized copy is the capture on the fall cycle.
    assign txn_valid                    = en_prev & ~sync[10];
    assign {txn_rs, txn_rw, txn_byte}   = sync[9:0];

endmodule

// File: rtl/lcd_hd44780_rx.sv
// HD44780 8-bit bus responder: decodes EN-strobed transactions into a DDRAM image and mode state.
// Optional busy timer and err_busy_write output enabled by defining LCD_RX_BUSY_EN.
module lcd_hd44780_rx
    import lcd_pkg::*;
#(
    parameter int unsigned CMD_CYCLES = 2000,
    parameter int unsigned CLR_CYCLES = 82000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       lcd_en,
    input  logic       lcd_rs,
    input  logic       lcd_rw,
    input  logic [7:0] lcd_data,
    input  logic [6:0] rd_addr,
    output logic [7:0] rd_data,
    output logic [6:0] cursor_addr,
    output logic       display_on,
    output logic       cursor_on,
    output logic       blink_on,
    output logic       entry_inc,
    output logic       entry_shift,
    output logic       two_line,
    output logic [5:0] shift_ofs,
    output logic       evt_valid,
    output logic       evt_rs,
    output logic [7:0] evt_byte,
    output logic       rw_ignored,
    output logic       busy
`ifdef LCD_RX_BUSY_EN
    ,
    output logic       err_busy_write
`endif
);

    logic       txn_valid, txn_rs, txn_rw;
    logic [7:0] txn_byte;

    lcd_bus_sync u_sync (
        .clk      (clk),
        .rst      (rst),
        .lcd_en   (lcd_en),
        .lcd_rs   (lcd_rs),
        .lcd_rw   (lcd_rw),
        .lcd_data (lcd_data),
        .txn_valid(txn_valid),
        .txn_rs   (txn_rs),
        .txn_rw   (txn_rw),
        .txn_byte (txn_byte)
    );

    state_t     state, state_nxt;
    logic [6:0] clr_cnt;
    logic       x_rs, x_rw;
    logic [7:0] x_byte;
    instr_t     x_cls;
    logic [7:0] mem [DDRAM_SIZE];
    logic       mem_we;
    logic [6:0] mem_idx;
    logic [7:0] mem_wdata;

    assign x_cls = instr_decode(x_byte);

    always_ff @(posedge clk) begin
        if (rst) state <= CLEAR;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        mem_we    = 1'b0;
        mem_idx   = clr_cnt;
        mem_wdata = SPACE_CHAR;
        case (state)
            CLEAR: begin
                mem_we = 1'b1;
                if (clr_cnt == 7'(DDRAM_SIZE - 1)) state_nxt = IDLE;
            end
            IDLE: if (txn_valid) state_nxt = EXEC;
            EXEC: begin
                if (!x_rw && x_rs) begin
                    mem_we    = 1'b1;
                    mem_idx   = ddram_index(cursor_addr);
                    mem_wdata = x_byte;
                end
                if (!x_rw && !x_rs && x_cls == I_CLEAR) state_nxt = CLEAR;
                else                                   state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (mem_we) mem[mem_idx] <= mem_wdata;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data     <= '0;
            clr_cnt     <= '0;
            cursor_addr <= '0;
            display_on  <= 1'b0;
            cursor_on   <= 1'b0;
            blink_on    <= 1'b0;
            entry_inc   <= 1'b1;
            entry_shift <= 1'b0;
            two_line    <= 1'b0;
            shift_ofs   <= '0;
            evt_valid   <= 1'b0;
            evt_rs      <= 1'b0;
            evt_byte    <= '0;
            rw_ignored  <= 1'b0;
            x_rs        <= 1'b0;
            x_rw        <= 1'b0;
            x_byte      <= '0;
        end else begin
            rd_data    <= col_valid(rd_addr) ? mem[ddram_index(rd_addr)] : SPACE_CHAR;
            evt_valid  <= 1'b0;
            rw_ignored <= 1'b0;
            case (state)
                CLEAR: clr_cnt <= clr_cnt + 7'd1;
                IDLE: if (txn_valid) begin
                    x_rs   <= txn_rs;
                    x_rw   <= txn_rw;
                    x_byte <= txn_byte;
                end
                EXEC: begin
                    clr_cnt <= '0;
                    if (x_rw) begin
                        rw_ignored <= 1'b1;
                    end else begin
                        evt_valid <= 1'b1;
                        evt_rs    <= x_rs;
                        evt_byte  <= x_byte;
                        if (x_rs) begin
                            cursor_addr <= ac_step(cursor_addr, entry_inc);
                            if (entry_shift) shift_ofs <= ofs_step(shift_ofs, entry_inc);
                        end else begin
                            case (x_cls)
                                I_CLEAR: begin
                                    cursor_addr <= '0;
                                    shift_ofs   <= '0;
                                    entry_inc   <= 1'b1;
                                end
                                I_HOME: begin
                                    cursor_addr <= '0;
                                    shift_ofs   <= '0;
                                end
                                I_ENTRY: begin
                                    entry_inc   <= x_byte[1];
                                    entry_shift <= x_byte[0];
                                end
                                I_DISPLAY: begin
                                    display_on <= x_byte[2];
                                    cursor_on  <= x_byte[1];
                                    blink_on   <= x_byte[0];
                                end
                                I_SHIFT: begin
                                    if (x_byte[3]) shift_ofs   <= ofs_step(shift_ofs, x_byte[2]);
                                    else           cursor_addr <= ac_step(cursor_addr, x_byte[2]);
                                end
                                I_FUNC:  two_line    <= x_byte[3];
                                I_DDRAM: cursor_addr <= ac_set(x_byte[6:0]);
                                default: ;
                            endcase
                        end
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef LCD_RX_BUSY_EN
    localparam int unsigned BUSY_MAX = (CLR_CYCLES > CMD_CYCLES) ? CLR_CYCLES : CMD_CYCLES;
    localparam int unsigned BW       = $clog2(BUSY_MAX + 1);

    logic [BW-1:0] busy_cnt;

    // The transaction still executes when busy; the error pulse only flags it.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_cnt       <= '0;
            err_busy_write <= 1'b0;
        end else begin
            err_busy_write <= 1'b0;
            if (state == EXEC && !x_rw) begin
                err_busy_write <= (busy_cnt != '0);
                busy_cnt <= (!x_rs && (x_cls == I_CLEAR || x_cls == I_HOME))
                            ? BW'(CLR_CYCLES) : BW'(CMD_CYCLES);
            end else if (busy_cnt != '0) begin
                busy_cnt <= busy_cnt - 1'b1;
            end
        end
    end

    assign busy = (busy_cnt != '0);
`else
    assign busy = 1'b0;
`endif

endmodule

// File: tb/tb_lcd_hd44780_rx.sv
// Self-checking bench for lcd_hd44780_rx against a linear-ring reference display model.
`timescale 1ns/1ps
module tb_lcd_hd44780_rx;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       lcd_en = 1'b0, lcd_rs = 1'b0, lcd_rw = 1'b0;
    logic [7:0] lcd_data = '0;
    logic [6:0] rd_addr = '0;
    logic [7:0] rd_data;
    logic [6:0] cursor_addr;
    logic       display_on, cursor_on, blink_on, entry_inc, entry_shift, two_line;
    logic [5:0] shift_ofs;
    logic       evt_valid, evt_rs, rw_ignored, busy;
    logic [7:0] evt_byte;
`ifdef LCD_RX_BUSY_EN
    logic       err_busy_write;
`endif

    lcd_hd44780_rx #(.CMD_CYCLES(10), .CLR_CYCLES(30)) dut (
        .clk(clk), .rst(rst), .lcd_en(lcd_en), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw),
        .lcd_data(lcd_data), .rd_addr(rd_addr), .rd_data(rd_data),
        .cursor_addr(cursor_addr), .display_on(display_on), .cursor_on(cursor_on),
        .blink_on(blink_on), .entry_inc(entry_inc), .entry_shift(entry_shift),
        .two_line(two_line), .shift_ofs(shift_ofs), .evt_valid(evt_valid),
        .evt_rs(evt_rs), .evt_byte(evt_byte), .rw_ignored(rw_ignored), .busy(busy)
`ifdef LCD_RX_BUSY_EN
        , .err_busy_write(err_busy_write)
`endif
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Reference model: cursor is a position 0..79 on one ring (line*40 + column).
    logic [7:0] m_mem [80];
    int         m_p, m_sh;
    bit         m_inc, m_s, m_d, m_c, m_b, m_n;

    int         n_evt, n_rwi, n_err, lat;
    logic       e_rs;
    logic [7:0] e_byte;

    function automatic logic [6:0] m_addr(input int p);
        return 7'((p / 40) * 64 + (p % 40));
    endfunction

    function automatic int lin(input logic [6:0] a);
        return (a[6] ? 40 : 0) + int'(a[5:0]);
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < 80; i++) m_mem[i] = 8'h20;
        m_p = 0; m_sh = 0; m_inc = 1; m_s = 0; m_d = 0; m_c = 0; m_b = 0; m_n = 0;
    endfunction

    function automatic void model_apply(input logic rs, input logic rw, input logic [7:0] b);
        int col;
        if (rw) return;
        if (rs) begin
            m_mem[m_p] = b;
            m_p = m_inc ? (m_p + 1) % 80 : (m_p + 79) % 80;
            if (m_s) m_sh = m_inc ? (m_sh + 1) % 40 : (m_sh + 39) % 40;
        end else if (b >= 8'h80) begin
            col = int'(b) % 64;
            if (col >= 40) col = 0;
            m_p = (b[6] ? 40 : 0) + col;
        end else if (b >= 8'h40) begin
        end else if (b >= 8'h20) begin
            m_n = b[3];
        end else if (b >= 8'h10) begin
            if (b[3]) m_sh = b[2] ? (m_sh + 1) % 40 : (m_sh + 39) % 40;
            else      m_p  = b[2] ? (m_p + 1) % 80 : (m_p + 79) % 80;
        end else if (b >= 8'h08) begin
            m_d = b[2]; m_c = b[1]; m_b = b[0];
        end else if (b >= 8'h04) begin
            m_inc = b[1]; m_s = b[0];
        end else if (b >= 8'h02) begin
            m_p = 0; m_sh = 0;
        end else if (b == 8'h01) begin
            for (int i = 0; i < 80; i++) m_mem[i] = 8'h20;
            m_p = 0; m_sh = 0; m_inc = 1;
        end
    endfunction

    task automatic send(input logic rs, input logic rw, input logic [7:0] b, input bit apply);
        @(negedge clk);
        lcd_rs = rs; lcd_rw = rw; lcd_data = b; lcd_en = 1'b1;
        repeat (3) @(negedge clk);
        lcd_en = 1'b0;
        n_evt = 0; n_rwi = 0; n_err = 0; lat = -1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (evt_valid) begin
                n_evt++;
                if (lat < 0) lat = i;
                e_rs = evt_rs; e_byte = evt_byte;
            end
            if (rw_ignored) n_rwi++;
`ifdef LCD_RX_BUSY_EN
            if (err_busy_write) n_err++;
`endif
        end
        if (apply) model_apply(rs, rw, b);
    endtask

    task automatic rd(input logic [6:0] a, output logic [7:0] d);
        @(negedge clk);
        rd_addr = a;
        @(negedge clk);
        d = rd_data;
    endtask

    task automatic test_reset();
        logic [7:0] d;
        logic [6:0] addrs [4];
        addrs = '{7'h00, 7'h27, 7'h40, 7'h67};
        rst = 1'b1;
        repeat (3) @(negedge clk);
        model_reset();
        tests++;
        if (cursor_addr !== 7'h00 || shift_ofs !== 6'd0 || entry_inc !== 1'b1 || rd_data !== 8'h00) begin
            fails++;
            $display("FAIL reset_core: ac=%h ofs=%0d inc=%b rd=%h, want 00 0 1 00",
                     cursor_addr, shift_ofs, entry_inc, rd_data);
        end
        tests++;
        if ({display_on, cursor_on, blink_on, entry_shift, two_line, evt_valid, rw_ignored, busy} !== 8'h00) begin
            fails++;
            $display("FAIL reset_flags: got %b want 00000000",
                     {display_on, cursor_on, blink_on, entry_shift, two_line, evt_valid, rw_ignored, busy});
        end
        rst = 1'b0;
        repeat (81) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            rd(addrs[i], d);
            tests++;
            if (d !== 8'h20) begin
                fails++;
                $display("FAIL reset_ddram[%h]: got %h want 20", addrs[i], d);
            end
        end
    endtask

    task automatic test_load();
        logic [7:0] seq [7];
        logic [7:0] d;
        int tot, first_lat;
        seq = '{8'h38, 8'h0C, 8'h06, 8'h4C, 8'h4F, 8'h41, 8'h44};
        tot = 0; first_lat = -1;
        for (int i = 0; i < 7; i++) begin
            send(i >= 3, 1'b0, seq[i], 1'b1);
            tot += n_evt;
            if (i == 0) first_lat = lat;
        end
        tests++;
        if (tot !== 7) begin fails++; $display("FAIL load_evt_count: got %0d want 7", tot); end
        tests++;
        if (first_lat !== 3) begin fails++; $display("FAIL evt_latency: got %0d want 3", first_lat); end
        tests++;
        if (two_line !== 1'b1 || display_on !== 1'b1 || cursor_on !== 1'b0 || cursor_addr !== 7'h04) begin
            fails++;
            $display("FAIL load_state: N=%b D=%b C=%b ac=%h want 1 1 0 04", two_line, display_on, cursor_on, cursor_addr);
        end
        tests++;
        if (e_rs !== 1'b1 || e_byte !== 8'h44) begin
            fails++; $display("FAIL load_evt_data: rs=%b byte=%h want 1 44", e_rs, e_byte);
        end
        for (int i = 0; i < 4; i++) begin
            rd(7'(i), d);
            tests++;
            if (d !== seq[3 + i]) begin
                fails++; $display("FAIL load_ddram[%0d]: got %h want %h", i, d, seq[3 + i]);
            end
        end
    endtask

    task automatic test_wrap();
        logic [7:0] d;
        send(1'b0, 1'b0, 8'hA7, 1'b1);
        send(1'b1, 1'b0, 8'h5B, 1'b1);
        tests++;
        if (cursor_addr !== 7'h40) begin fails++; $display("FAIL wrap_inc: ac=%h want 40", cursor_addr); end
        rd(7'h27, d);
        tests++;
        if (d !== 8'h5B) begin fails++; $display("FAIL wrap_ddram27: got %h want 5b", d); end
        send(1'b0, 1'b0, 8'h04, 1'b1);
        send(1'b0, 1'b0, 8'h80, 1'b1);
        send(1'b1, 1'b0, 8'h21, 1'b1);
        tests++;
        if (cursor_addr !== 7'h67 || entry_inc !== 1'b0) begin
            fails++; $display("FAIL wrap_dec: ac=%h inc=%b want 67 0", cursor_addr, entry_inc);
        end
        send(1'b0, 1'b0, 8'h06, 1'b1);
    endtask

    task automatic test_cursor_shift();
        send(1'b0, 1'b0, 8'h82, 1'b1);
        repeat (3) send(1'b0, 1'b0, 8'h14, 1'b1);
        tests++;
        if (cursor_addr !== 7'h05) begin fails++; $display("FAIL cursor_right: ac=%h want 05", cursor_addr); end
        repeat (41) send(1'b0, 1'b0, 8'h1C, 1'b1);
        tests++;
        if (shift_ofs !== 6'd1 || cursor_addr !== 7'h05) begin
            fails++; $display("FAIL display_shift: ofs=%0d ac=%h want 1 05", shift_ofs, cursor_addr);
        end
        send(1'b0, 1'b0, 8'hB0, 1'b1);
        tests++;
        if (cursor_addr !== 7'h00) begin fails++; $display("FAIL set_ac_b0: ac=%h want 00", cursor_addr); end
        send(1'b0, 1'b0, 8'hF0, 1'b1);
        tests++;
        if (cursor_addr !== 7'h40) begin fails++; $display("FAIL set_ac_f0: ac=%h want 40", cursor_addr); end
        send(1'b0, 1'b0, 8'hE7, 1'b1);
        tests++;
        if (cursor_addr !== 7'h67) begin fails++; $display("FAIL set_ac_e7: ac=%h want 67", cursor_addr); end
    endtask

    task automatic test_rw_and_clear();
        logic [7:0] d;
        logic [6:0] addrs [5];
        addrs = '{7'h00, 7'h27, 7'h40, 7'h67, 7'h03};
        send(1'b0, 1'b1, 8'h80, 1'b1);
        tests++;
        if (n_rwi !== 1 || n_evt !== 0 || cursor_addr !== 7'h67) begin
            fails++; $display("FAIL rw_ignored: rwi=%0d evt=%0d ac=%h want 1 0 67", n_rwi, n_evt, cursor_addr);
        end
        send(1'b0, 1'b0, 8'h01, 1'b1);
        tests++;
        if (n_evt !== 1) begin fails++; $display("FAIL clear_evt: got %0d want 1", n_evt); end
        send(1'b1, 1'b0, 8'h58, 1'b0);
        tests++;
        if (n_evt !== 0) begin fails++; $display("FAIL sweep_drop: evt=%0d want 0", n_evt); end
        repeat (90) @(negedge clk);
        tests++;
        if (cursor_addr !== 7'h00 || shift_ofs !== 6'd0 || entry_inc !== 1'b1) begin
            fails++; $display("FAIL clear_state: ac=%h ofs=%0d inc=%b want 00 0 1", cursor_addr, shift_ofs, entry_inc);
        end
        for (int i = 0; i < 5; i++) begin
            rd(addrs[i], d);
            tests++;
            if (d !== 8'h20) begin fails++; $display("FAIL clear_ddram[%h]: got %h want 20", addrs[i], d); end
        end
    endtask

    task automatic test_random();
        logic       rs, rw;
        logic [7:0] b, d;
        logic [6:0] a;
        int         r;
        for (int n = 0; n < 120; n++) begin
            r  = int'($urandom_range(0, 99));
            rw = (r < 8);
            rs = (r >= 40);
            b  = 8'($urandom);
            if (!rs && b == 8'h01) b = 8'h03;
            send(rs, rw, b, 1'b1);
            tests++;
            if (rw ? (n_rwi !== 1 || n_evt !== 0) : (n_evt !== 1 || e_rs !== rs || e_byte !== b || n_rwi !== 0)) begin
                fails++;
                $display("FAIL rnd_evt[%0d]: evt=%0d rwi=%0d rs=%b byte=%h want rw=%b rs=%b byte=%h",
                         n, n_evt, n_rwi, e_rs, e_byte, rw, rs, b);
            end
            tests++;
            if (cursor_addr !== m_addr(m_p) || shift_ofs !== 6'(m_sh) || busy === 1'bx ||
                {display_on, cursor_on, blink_on, entry_inc, entry_shift, two_line} !== {m_d, m_c, m_b, m_inc, m_s, m_n}) begin
                fails++;
                $display("FAIL rnd_state[%0d]: ac=%h ofs=%0d flags=%b want ac=%h ofs=%0d flags=%b",
                         n, cursor_addr, shift_ofs,
                         {display_on, cursor_on, blink_on, entry_inc, entry_shift, two_line},
                         m_addr(m_p), m_sh, {m_d, m_c, m_b, m_inc, m_s, m_n});
            end
        end
        for (int p = 0; p < 80; p++) begin
            rd(m_addr(p), d);
            tests++;
            if (d !== m_mem[p]) begin fails++; $display("FAIL rnd_ddram[%h]: got %h want %h", m_addr(p), d, m_mem[p]); end
        end
        for (int k = 0; k < 6; k++) begin
            a = {1'($urandom_range(0, 1)), 6'($urandom_range(40, 63))};
            rd(a, d);
            tests++;
            if (d !== 8'h20 || lin(a) < 40) begin fails++; $display("FAIL bad_col_read[%h]: got %h want 20", a, d); end
        end
    endtask

`ifdef LCD_RX_BUSY_EN
    task automatic test_busy();
        logic [7:0] d;
        repeat (40) @(negedge clk);
        send(1'b0, 1'b0, 8'h02, 1'b1);
        tests++;
        if (busy !== 1'b1 || n_err !== 0) begin fails++; $display("FAIL busy_home: busy=%b err=%0d want 1 0", busy, n_err); end
        send(1'b1, 1'b0, 8'h7E, 1'b1);
        tests++;
        if (n_err !== 1 || n_evt !== 1) begin fails++; $display("FAIL busy_err: err=%0d evt=%0d want 1 1", n_err, n_evt); end
        rd(7'h00, d);
        tests++;
        if (d !== 8'h7E) begin fails++; $display("FAIL busy_write_lands: got %h want 7e", d); end
        repeat (40) @(negedge clk);
        tests++;
        if (busy !== 1'b0) begin fails++; $display("FAIL busy_expire: busy=%b want 0", busy); end
        send(1'b0, 1'b0, 8'h0C, 1'b1);
        tests++;
        if (n_err !== 0) begin fails++; $display("FAIL busy_idle_err: err=%0d want 0", n_err); end
    endtask
`endif

    initial begin
        test_reset();
        test_load();
        test_wrap();
        test_cursor_shift();
        test_rw_and_clear();
        test_random();
`ifdef LCD_RX_BUSY_EN
        test_busy();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached, tests=%0d", tests);
        $fatal(1);
    end

endmodule
